rv32i_irq_timer_ctrl: RTL and testbench
=======================================

Name: rv32i_irq_timer_ctrl

Overview:
- Memory-mapped interrupt/timer front-end that sits directly upstream of rv32i_soc and drives its interrupt and timer ports (i_external_interrupt, i_software_interrupt, i_mtime_wr, i_mtimecmp_wr, i_mtime_din, i_mtimecmp_din).
- A 32-bit register bus loads 64-bit mtime/mtimecmp through shadow halves and commits each as one 64-bit write pulse.
- Software interrupt comes from an MSIP bit. An asynchronous external interrupt line is synchronised and latched.
- Pending sources are cleared by the core's trap-entry acknowledge (writeback_ce && csr_go_to_trap).

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the external-interrupt synchroniser; legal values 2..4.
- MTIMECMP_RESET, 64'hFFFF_FFFF_FFFF_FFFF, value committed to mtimecmp immediately after reset release.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_stb  in  1  bus access request; each high cycle is one independent access.
- i_we  in  1  1 = write, 0 = read.
- i_addr  in  3  word offset of the register.
- i_wr_data  in  32  write data.
- i_wr_mask  in  4  byte enables for the write.
- o_ack  out  1  access complete; asserted 1 cycle after i_stb.
- o_rd_data  out  32  read data; valid when o_ack is high.
- i_ext_irq  in  1  asynchronous external interrupt line.
- i_trap_ack  in  1  one-cycle pulse from the core on trap entry.
- o_external_interrupt  out  1  to rv32i_soc.
- o_software_interrupt  out  1  to rv32i_soc.
- o_mtime_wr  out  1  one-cycle commit strobe for mtime.
- o_mtimecmp_wr  out  1  one-cycle commit strobe for mtimecmp.
- o_mtime_din  out  64  mtime commit value.
- o_mtimecmp_din  out  64  mtimecmp commit value.

Behaviour:
- Register map (word offsets):
  - 0 MSIP: bit0 only, RW.
  - 1 CMP_LO: RW shadow.
  - 2 CMP_HI: RW shadow; a write commits mtimecmp.
  - 3 TIME_LO: RW shadow.
  - 4 TIME_HI: RW shadow; a write commits mtime.
  - 5 CTRL: bit0 EXT_EN, RW.
  - 6 STATUS, read: {29'b0, ext_pend, sw_pend, init_busy}; write: a 1 in bit2 clears ext_pend.
  - 7: reads 0; writes ignored.
- Writes apply i_wr_mask per byte. A commit fires even if only some bytes of the HI register are written.
- Reset (asynchronous, i_rst_n low): all shadows 0, MSIP 0, EXT_EN 0, ext_pend 0, synchroniser 0, o_ack 0, o_rd_data 0, both *_wr strobes 0, o_mtime_din 0, o_mtimecmp_din 0, init_busy 1.
- Init state machine, INIT -> RUN:
  - First i_clk edge with i_rst_n high: o_mtimecmp_wr = 1 with o_mtimecmp_din = MTIMECMP_RESET; init_busy goes to 0.
  - While in INIT, o_ack still answers bus accesses, but commits requested in that same cycle are deferred by one cycle.
  - Reset asserted mid-operation returns the block to INIT and drops every strobe immediately.
- Commit timing: an i_stb write to CMP_HI in cycle N gives o_mtimecmp_wr = 1 in cycle N+1, with o_mtimecmp_din = {new HI, CMP_LO}. TIME_HI behaves the same way for mtime.
  - *_din holds its value after the strobe until the next commit.
  - Strobes last exactly 1 cycle. Back-to-back HI writes give back-to-back pulses.
- Bus: o_ack = registered i_stb. o_rd_data is registered in the same cycle and is 0 when not acking.
- External interrupt:
  - i_ext_irq passes through SYNC_STAGES flops.
  - A rising edge of the synchronised signal while EXT_EN = 1 sets ext_pend. The edge is ignored when EXT_EN = 0.
  - o_external_interrupt = ext_pend.
- Software interrupt: sw_pend = MSIP; o_software_interrupt = MSIP.
- Trap acknowledge, priority external > software:
  - If ext_pend, i_trap_ack clears ext_pend.
  - Otherwise, if MSIP, i_trap_ack clears MSIP.
  - One source is cleared per acknowledge.
- Simultaneous events:
  - Edge set and ack clear of ext_pend in the same cycle: set wins.
  - Bus write to MSIP and ack in the same cycle: the bus write wins.
  - STATUS clear and edge set in the same cycle: set wins.
- The timer interrupt itself is produced inside rv32i_soc; this block only loads mtime and mtimecmp.

Optional Feature:
- Macro IRQ_TIMER_EXT_LEVEL_EN.
- Defined:
  - External interrupt is level-sensitive: o_external_interrupt = sync_out & EXT_EN, with no latch.
  - i_trap_ack never affects the external source, and skips straight to clearing MSIP.
  - STATUS bit2 reads the synchronised level; writes to bit2 are ignored.
- Undefined: edge-latched behaviour as specified above.

Test Plan:
- Release reset and idle 3 cycles -> exactly one o_mtimecmp_wr pulse, 1 cycle after release, with din = 64'hFFFF_FFFF_FFFF_FFFF; STATUS reads 0.
- Write CMP_LO = 0x0000_000F, then CMP_HI = 0 -> one o_mtimecmp_wr pulse 1 cycle after the HI stb, din = 64'h0000_0000_0000_000F; o_ack high on each following cycle.
- Write TIME_HI with mask 4'b0001, data 0xAB, TIME_LO preloaded 0x1234 -> o_mtime_wr pulse, o_mtime_din = 64'h0000_00AB_0000_1234.
- CTRL = 1, pulse i_ext_irq for 3 cycles -> o_external_interrupt rises SYNC_STAGES+1 cycles after the edge and stays high; i_trap_ack -> drops next cycle. With EXT_EN = 0 the same pulse gives no response.
- MSIP = 1 and ext_pend = 1, then two i_trap_ack pulses -> first clears external only, second clears software.
- Assert i_rst_n low mid-commit (during a CMP_HI write cycle) -> strobes drop to 0 immediately; after release only the MTIMECMP_RESET init pulse occurs.

Source files
------------

// File: rtl/rv32i_irq_timer_ctrl.sv
// rv32i_irq_timer_ctrl: bus-mapped mtime/mtimecmp loader and MSIP/external interrupt front-end for rv32i_soc.
// Define IRQ_TIMER_EXT_LEVEL_EN for a level-sensitive external interrupt with no pending latch.
module rv32i_irq_timer_ctrl #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stb,
    input  logic        i_we,
    input  logic [2:0]  i_addr,
    input  logic [31:0] i_wr_data,
    input  logic [3:0]  i_wr_mask,
    output logic        o_ack,
    output logic [31:0] o_rd_data,
    input  logic        i_ext_irq,
    input  logic        i_trap_ack,
    output logic        o_external_interrupt,
    output logic        o_software_interrupt,
    output logic        o_mtime_wr,
    output logic        o_mtimecmp_wr,
    output logic [63:0] o_mtime_din,
    output logic [63:0] o_mtimecmp_din
);
    typedef enum logic {INIT, RUN} state_t;
    state_t state, state_next;
    logic init_busy, msip, ext_en, ext_pend, status_ext, sync_out, ack_ext, ack_sw;
    logic defer_cmp, defer_time, wr, wr_cmp_hi, wr_time_hi;
    logic [SYNC_STAGES-1:0] sync;
    logic [31:0] cmp_lo, cmp_hi, time_lo, time_hi, rd_mux, wr_merged;

    assign wr                   = i_stb & i_we;
    assign wr_cmp_hi            = wr & (i_addr == 3'd2);
    assign wr_time_hi           = wr & (i_addr == 3'd4);
    assign sync_out             = sync[SYNC_STAGES-1];
    assign ack_sw               = i_trap_ack & ~ack_ext & msip;
    assign o_external_interrupt = ext_pend;
    assign o_software_interrupt = msip;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) state <= INIT;
        else state <= state_next;

    always_comb begin
        state_next = state;
        init_busy  = (state == INIT);
        if (state == INIT) state_next = RUN;
    end

    always_comb begin
        rd_mux = '0;
        case (i_addr)
            3'd0:    rd_mux = {31'b0, msip};
            3'd1:    rd_mux = cmp_lo;
            3'd2:    rd_mux = cmp_hi;
            3'd3:    rd_mux = time_lo;
            3'd4:    rd_mux = time_hi;
            3'd5:    rd_mux = {31'b0, ext_en};
            3'd6:    rd_mux = {29'b0, status_ext, msip, init_busy};
            default: rd_mux = '0;
        endcase
    end

    // Byte-masked write value, merged over the register's current contents
    always_comb begin
        wr_merged = rd_mux;
        for (int b = 0; b < 4; b++)
            wr_merged[b*8 +: 8] = i_wr_mask[b] ? i_wr_data[b*8 +: 8] : rd_mux[b*8 +: 8];
    end

`ifdef IRQ_TIMER_EXT_LEVEL_EN
    assign ext_pend   = sync_out & ext_en;
    assign status_ext = sync_out;
    assign ack_ext    = 1'b0;
`else
    logic sync_prev, ext_set, ext_clr;
    assign ext_set    = sync_out & ~sync_prev & ext_en;
    assign ack_ext    = i_trap_ack & ext_pend;
    assign ext_clr    = ack_ext | (wr & (i_addr == 3'd6) & i_wr_mask[0] & i_wr_data[2]);
    assign status_ext = ext_pend;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            sync_prev <= 1'b0;
            ext_pend  <= 1'b0;
        end else begin
            sync_prev <= sync_out;
            ext_pend  <= ext_set | (ext_pend & ~ext_clr);
        end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            sync           <= '0;
            msip           <= 1'b0;
            ext_en         <= 1'b0;
            cmp_lo         <= '0;
            cmp_hi         <= '0;
            time_lo        <= '0;
            time_hi        <= '0;
            o_ack          <= 1'b0;
            o_rd_data      <= '0;
            o_mtime_wr     <= 1'b0;
            o_mtimecmp_wr  <= 1'b0;
            o_mtime_din    <= '0;
            o_mtimecmp_din <= '0;
            defer_cmp      <= 1'b0;
            defer_time     <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], i_ext_irq};
            o_ack     <= i_stb;
            o_rd_data <= i_stb ? rd_mux : '0;
            msip      <= (wr && i_addr == 3'd0) ? wr_merged[0] : msip & ~ack_sw;
            if (wr && i_addr == 3'd5) ext_en <= wr_merged[0];
            if (wr && i_addr == 3'd1) cmp_lo <= wr_merged;
            if (wr_cmp_hi) cmp_hi <= wr_merged;
            if (wr && i_addr == 3'd3) time_lo <= wr_merged;
            if (wr_time_hi) time_hi <= wr_merged;
            // The init commit owns the first cycle; HI writes landing there fire one cycle later
            if (state == INIT) begin
                o_mtimecmp_wr  <= 1'b1;
                o_mtimecmp_din <= MTIMECMP_RESET;
                o_mtime_wr     <= 1'b0;
                defer_cmp      <= wr_cmp_hi;
                defer_time     <= wr_time_hi;
            end else begin
                o_mtimecmp_wr <= wr_cmp_hi | defer_cmp;
                o_mtime_wr    <= wr_time_hi | defer_time;
                defer_cmp     <= 1'b0;
                defer_time    <= 1'b0;
                if (wr_cmp_hi) o_mtimecmp_din <= {wr_merged, cmp_lo};
                else if (defer_cmp) o_mtimecmp_din <= {cmp_hi, cmp_lo};
                if (wr_time_hi) o_mtime_din <= {wr_merged, time_lo};
                else if (defer_time) o_mtime_din <= {time_hi, time_lo};
            end
        end
endmodule

// File: tb/tb_rv32i_irq_timer_ctrl.sv
// tb_rv32i_irq_timer_ctrl: directed scoreboard bench for rv32i_irq_timer_ctrl.
module tb_rv32i_irq_timer_ctrl;
    localparam int unsigned SS = 2;
    localparam logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0, we = 1'b0, ext_irq = 1'b0, trap_ack = 1'b0;
    logic [2:0]  addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_mask = '0;
    logic        ack, ext_int, sw_int, mtime_wr, mtimecmp_wr;
    logic [31:0] rd_data;
    logic [63:0] mtime_din, mtimecmp_din;

    int checks = 0, failures = 0, cmp_cnt = 0, time_cnt = 0, base;
    logic [63:0] cmp_q[$], time_q[$];
    logic [32:0] ack_q[$];

    always #5 clk = ~clk;

    rv32i_irq_timer_ctrl #(.SYNC_STAGES(SS), .MTIMECMP_RESET(CMP_RST)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stb(stb), .i_we(we), .i_addr(addr),
        .i_wr_data(wr_data), .i_wr_mask(wr_mask), .o_ack(ack), .o_rd_data(rd_data),
        .i_ext_irq(ext_irq), .i_trap_ack(trap_ack), .o_external_interrupt(ext_int),
        .o_software_interrupt(sw_int), .o_mtime_wr(mtime_wr), .o_mtimecmp_wr(mtimecmp_wr),
        .o_mtime_din(mtime_din), .o_mtimecmp_din(mtimecmp_din)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one clock and retire whatever the DUT produced against the scoreboard
    task automatic step();
        logic [32:0] e;
        @(posedge clk);
        #1;
        if (mtimecmp_wr) begin
            cmp_cnt++;
            if (cmp_q.size() == 0) chk1("cmp_unexpected", mtimecmp_wr, 1'b0);
            else chk("cmp_din", mtimecmp_din, cmp_q.pop_front());
        end
        if (mtime_wr) begin
            time_cnt++;
            if (time_q.size() == 0) chk1("time_unexpected", mtime_wr, 1'b0);
            else chk("time_din", mtime_din, time_q.pop_front());
        end
        chk1("ack", ack, ack_q.size() != 0);
        if (ack && ack_q.size() != 0) begin
            e = ack_q.pop_front();
            if (e[32]) chk("rd_data", 64'(rd_data), 64'(e[31:0]));
        end else if (!ack) chk("rd_idle", 64'(rd_data), 64'h0);
    endtask

    task automatic bus(input logic w, input logic [2:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic [31:0] exp_rd);
        stb = 1'b1; we = w; addr = a; wr_data = d; wr_mask = m;
        ack_q.push_back({~w, exp_rd});
        step();
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] m);
        bus(1'b1, a, d, m, 32'h0);
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp_rd);
        bus(1'b0, a, 32'h0, 4'h0, exp_rd);
    endtask

    task automatic ext_pulse();
        ext_irq = 1'b1;
        repeat (3) step();
        ext_irq = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_cmp_wr", mtimecmp_wr, 1'b0);
        chk1("rst_time_wr", mtime_wr, 1'b0);
        chk("rst_cmp_din", mtimecmp_din, 64'h0);
        chk("rst_time_din", mtime_din, 64'h0);
        chk1("rst_ack", ack, 1'b0);
        chk1("rst_ext", ext_int, 1'b0);
        chk1("rst_sw", sw_int, 1'b0);

        // Release: exactly one init pulse one cycle later
        cmp_q.push_back(CMP_RST);
        rst_n = 1'b1;
        step();
        chk("init_pulse_cnt", 64'(cmp_cnt), 64'd1);
        repeat (2) step();
        chk("init_only_one", 64'(cmp_cnt), 64'd1);
        rd(3'd6, 32'h0);

        // mtimecmp commit
        wr(3'd1, 32'h0000_000F, 4'hF);
        cmp_q.push_back(64'h0000_0000_0000_000F);
        wr(3'd2, 32'h0, 4'hF);
        step();
        chk("cmp_din_hold", mtimecmp_din, 64'h0000_0000_0000_000F);
        chk("cmp_cnt2", 64'(cmp_cnt), 64'd2);

        // mtime commit with partial mask
        wr(3'd3, 32'h0000_1234, 4'hF);
        time_q.push_back(64'h0000_00AB_0000_1234);
        wr(3'd4, 32'hFFFF_FFAB, 4'b0001);
        chk("time_cnt1", 64'(time_cnt), 64'd1);
        rd(3'd4, 32'h0000_00AB);

        // Back-to-back HI writes
        base = cmp_cnt;
        cmp_q.push_back(64'h0000_0001_0000_000F);
        cmp_q.push_back(64'h0000_0002_0000_000F);
        wr(3'd2, 32'h1, 4'hF);
        wr(3'd2, 32'h2, 4'hF);
        chk("b2b_cnt", 64'(cmp_cnt - base), 64'd2);

        // External edge latched with EXT_EN=1
        wr(3'd5, 32'h1, 4'hF);
        ext_irq = 1'b1;
        for (int i = 1; i <= SS + 1; i++) begin
            step();
            if (i == 3) ext_irq = 1'b0;
            chk1("ext_rise", ext_int, i == SS + 1);
        end
        ext_irq = 1'b0;
        repeat (3) step();
        chk1("ext_stays", ext_int, 1'b1);
        rd(3'd6, 32'h4);
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        chk1("ext_ack_clear", ext_int, 1'b0);

        // Edge ignored with EXT_EN=0
        wr(3'd5, 32'h0, 4'hF);
        ext_pulse();
        step();
        chk1("ext_disabled", ext_int, 1'b0);

        // Priority: external then software
        wr(3'd0, 32'h1, 4'hF);
        chk1("msip_set", sw_int, 1'b1);
        wr(3'd5, 32'h1, 4'hF);
        ext_pulse();
        chk1("both_ext", ext_int, 1'b1);
        rd(3'd6, 32'h6);
        trap_ack = 1'b1;
        step();
        chk1("ack1_ext", ext_int, 1'b0);
        chk1("ack1_sw", sw_int, 1'b1);
        step();
        trap_ack = 1'b0;
        chk1("ack2_sw", sw_int, 1'b0);
        rd(3'd0, 32'h0);

        // Bus write to MSIP beats a simultaneous acknowledge
        trap_ack = 1'b1;
        wr(3'd0, 32'h1, 4'hF);
        trap_ack = 1'b0;
        chk1("msip_wr_wins", sw_int, 1'b1);
        wr(3'd0, 32'h0, 4'hF);

        // STATUS write clears ext_pend
        ext_pulse();
        chk1("ext_set_again", ext_int, 1'b1);
        wr(3'd6, 32'h4, 4'h1);
        chk1("status_clear", ext_int, 1'b0);

        // Reset during a commit drops strobes immediately
        cmp_q.push_back(64'h0000_0007_0000_000F);
        wr(3'd2, 32'h7, 4'hF);
        chk1("pre_rst_strobe", mtimecmp_wr, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("rst_drop_cmp", mtimecmp_wr, 1'b0);
        chk("rst_drop_din", mtimecmp_din, 64'h0);
        chk1("rst_drop_ack", ack, 1'b0);
        repeat (2) step();
        base = cmp_cnt;
        cmp_q.push_back(CMP_RST);
        rst_n = 1'b1;
        repeat (3) step();
        chk("rst_only_init", 64'(cmp_cnt - base), 64'd1);
        rd(3'd1, 32'h0);

        // HI write during INIT is deferred one cycle behind the init pulse
        rst_n = 1'b0;
        repeat (2) step();
        cmp_q.push_back(CMP_RST);
        cmp_q.push_back(64'h0000_0005_0000_0000);
        rst_n = 1'b1;
        wr(3'd2, 32'h5, 4'hF);
        step();
        chk("defer_drained", 64'(cmp_q.size()), 64'd0);
        chk("queues_drained", 64'(time_q.size() + ack_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
